wireless_tx_buffer: RTL and testbench

Byte buffer between the MCU-side UART receiver and the node-side UART transmitter, on the wireless transmit path of the RF transceiver.
- Accepts bytes as the UART_mcu RX flag pulses and stores them in a 512-deep FIFO.
- Releases a burst to the UART_node transmitter when the fill level reaches the start threshold, or when the MCU has gone idle.
- Drives AUX low while any data is pending or in flight.

---
 rtl/wireless_tx_buffer_pkg.sv | 27 ++
 rtl/wireless_tx_buffer_if.sv | 52 +++++
 rtl/wireless_tx_fifo.sv | 65 ++++++
 rtl/wireless_tx_buffer.sv | 147 ++++++++++++++
 tb/tb_wireless_tx_buffer.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wireless_tx_buffer_pkg.sv
// wireless_tx_buffer shared types and sizing helpers.
// FSM encoding, width functions and default thresholds.
package wireless_tx_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int unsigned DEF_START   = 58;
  localparam int unsigned DEF_TIMEOUT = 200000;

  function automatic int unsigned ptr_w(
    input int unsigned depth
  );
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra bit so the count can hold DEPTH itself.
  function automatic int unsigned cnt_w(
    input int unsigned depth
  );
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wireless_tx_buffer_if.sv
// MCU/node byte bus for wireless_tx_buffer.
// drop_count exists only with WIRELESS_TX_BUFFER_DROP_COUNTER_EN.
interface wireless_tx_buffer_if #(
  parameter int DW = 8,
  parameter int CW = 10
);

  logic [DW-1:0] data_in;
  logic          RX_flag_in;
  logic [DW-1:0] data_out;
  logic          TX_use_out;
  logic          TX_flag_in;
  logic          AUX;
  logic [CW-1:0] fill_count;
  logic          overflow;
`ifdef WIRELESS_TX_BUFFER_DROP_COUNTER_EN
  logic [15:0]   drop_count;

  modport slave (
    input  data_in, RX_flag_in,
    input  TX_flag_in,
    output data_out, TX_use_out,
    output AUX, fill_count,
    output overflow, drop_count
  );

  modport master (
    output data_in, RX_flag_in,
    output TX_flag_in,
    input  data_out, TX_use_out,
    input  AUX, fill_count,
    input  overflow, drop_count
  );
`else
  modport slave (
    input  data_in, RX_flag_in,
    input  TX_flag_in,
    output data_out, TX_use_out,
    output AUX, fill_count,
    output overflow
  );

  modport master (
    output data_in, RX_flag_in,
    output TX_flag_in,
    input  data_out, TX_use_out,
    input  AUX, fill_count,
    input  overflow
  );
`endif

endinterface

// File: rtl/wireless_tx_fifo.sv
// Dual-pointer synchronous FIFO with exact count.
// A push into a full FIFO is taken only alongside a pop.
module wireless_tx_fifo
  import wireless_tx_buffer_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 512,
  parameter int PW    = ptr_w(DEPTH),
  parameter int CW    = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_wr;
  logic w_rd;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  assign w_rd = i_pop && !o_empty;
  assign w_wr = i_push && (!o_full || w_rd);

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Power-of-two depth: pointers wrap by overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      unique case (1'b1)
        (w_wr && !w_rd): r_count <= r_count + CW'(1);
        (w_rd && !w_wr): r_count <= r_count - CW'(1);
        default:         r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wireless_tx_buffer.sv
// MCU->node byte buffer with threshold/idle-flush bursts.
// Optional drop counter: WIRELESS_TX_BUFFER_DROP_COUNTER_EN.
module wireless_tx_buffer
  import wireless_tx_buffer_pkg::*;
#(
  parameter int DATA_WIDTH                  = 8,
  parameter int FIFO_DEPTH                  = 512,
  parameter int START_WIRELESS_TRANS_VALUE  = DEF_START,
  parameter int END_WAITING_SEND_WLESS_DATA = DEF_TIMEOUT
) (
  input logic internal_clk,
  input logic rst_n,
  wireless_tx_buffer_if.slave bus
);

  localparam int CW = cnt_w(FIFO_DEPTH);
  localparam int TW = $clog2(END_WAITING_SEND_WLESS_DATA);
  localparam logic [TW-1:0] TMAX =
    TW'(END_WAITING_SEND_WLESS_DATA - 1);
  localparam logic [CW-1:0] START =
    CW'(START_WIRELESS_TRANS_VALUE);

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_tx_use;
  logic                  r_aux;
  logic                  r_ovf;
  logic [TW-1:0]         r_timer;

  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_full;
  logic                  w_empty;
  logic [CW-1:0]         w_count;
  logic [CW-1:0]         w_cnt_nxt;
  logic                  w_pop;
  logic                  w_push_ok;
  logic                  w_drop;
  logic                  w_go;

  wireless_tx_fifo #(
    .DW    (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (internal_clk),
    .rst_n   (rst_n),
    .i_push  (bus.RX_flag_in),
    .i_pop   (w_pop),
    .i_data  (bus.data_in),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_pop = (r_state == SEND) &&
                 !bus.TX_flag_in && !w_empty;
  assign w_push_ok = bus.RX_flag_in &&
                     (!w_full || w_pop);
  assign w_drop = bus.RX_flag_in &&
                  w_full && !w_pop;
  assign w_go = (w_count >= START) ||
                (!w_empty && r_timer == TMAX);

  always_comb begin
    w_cnt_nxt = w_count;
    if (w_push_ok && !w_pop) begin
      w_cnt_nxt = w_count + CW'(1);
    end else if (w_pop && !w_push_ok) begin
      w_cnt_nxt = w_count - CW'(1);
    end
  end

  // AUX is registered from next-state and next-count.
  always_ff @(posedge internal_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_data_out <= '0;
      r_tx_use   <= 1'b0;
      r_aux      <= 1'b0;
      r_ovf      <= 1'b0;
      r_timer    <= '0;
    end else begin
      r_tx_use <= w_pop;
      r_ovf    <= w_drop;
      if (w_pop) begin
        r_data_out <= w_head;
      end
      if (w_push_ok || w_empty) begin
        r_timer <= '0;
      end else if (r_state == IDLE &&
                   r_timer != TMAX) begin
        r_timer <= r_timer + TW'(1);
      end
      unique case (r_state)
        IDLE: begin
          if (w_go) begin
            r_state <= SEND;
            r_aux   <= 1'b0;
          end else begin
            r_aux <= (w_cnt_nxt == '0);
          end
        end
        SEND: begin
          if (w_empty) begin
            r_state <= IDLE;
            r_aux   <= (w_cnt_nxt == '0);
          end else if (!bus.TX_flag_in) begin
            r_state <= HOLD;
            r_aux   <= 1'b0;
          end else begin
            r_aux <= 1'b0;
          end
        end
        HOLD: begin
          r_state <= SEND;
          r_aux   <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_aux   <= 1'b0;
        end
      endcase
    end
  end

`ifdef WIRELESS_TX_BUFFER_DROP_COUNTER_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge internal_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop &&
                 r_drop_cnt != 16'hFFFF) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign bus.drop_count = r_drop_cnt;
`endif

  assign bus.data_out   = r_data_out;
  assign bus.TX_use_out = r_tx_use;
  assign bus.AUX        = r_aux;
  assign bus.fill_count = w_count;
  assign bus.overflow   = r_ovf;

endmodule

// File: tb/tb_wireless_tx_buffer.sv
// Directed bench for wireless_tx_buffer.
// Timeout shortened to 100 cycles for the idle-flush steps.
module tb_wireless_tx_buffer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wireless_tx_buffer_if #(.DW(8), .CW(10)) bif ();

  wireless_tx_buffer #(
    .DATA_WIDTH                  (8),
    .FIFO_DEPTH                  (512),
    .START_WIRELESS_TRANS_VALUE  (58),
    .END_WAITING_SEND_WLESS_DATA (100)
  ) dut (
    .internal_clk (clk),
    .rst_n        (rst_n),
    .bus          (bif)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] q[$];
  int tq[$];
  int ovf_cnt = 0;

  always @(negedge clk) begin
    if (bif.TX_use_out === 1'b1) begin
      q.push_back(bif.data_out);
      tq.push_back(cyc);
    end
    if (bif.overflow === 1'b1) ovf_cnt++;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    bif.data_in    = b;
    bif.RX_flag_in = 1'b1;
    tick(1);
    bif.RX_flag_in = 1'b0;
  endtask

  task automatic wait_q(input int n, input int budget);
    int k;
    k = 0;
    while (q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
  endtask

  initial begin
    int n, p, e, n0, n1, ov0, bad, gap;
    bif.data_in    = '0;
    bif.RX_flag_in = 1'b0;
    bif.TX_flag_in = 1'b0;

    #3;
    chk("rst_aux", bif.AUX, 0);
    chk("rst_fill", bif.fill_count, 0);
    chk("rst_txuse", bif.TX_use_out, 0);
    chk("rst_dout", bif.data_out, 0);
    chk("rst_ovf", bif.overflow, 0);
`ifdef WIRELESS_TX_BUFFER_DROP_COUNTER_EN
    chk("rst_dropcnt", bif.drop_count, 0);
`endif
    #4 rst_n = 1'b1;
    tick(1);
    chk("aux_after_rst", bif.AUX, 1);

    // Threshold burst
    for (int i = 0; i < 57; i++) begin
      push(8'(i));
      tick(3);
    end
    chk("t1_no_early", q.size(), 0);
    chk("t1_fill57", bif.fill_count, 57);
    chk("t1_aux_busy", bif.AUX, 0);
    push(8'd57);
    n = cyc;
    wait_q(58, 400);
    chk("t1_count", q.size(), 58);
    chk("t1_latency", tq[0] - n, 2);
    bad = 0;
    gap = 0;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i] !== 8'(i)) bad++;
      if (i > 0 && tq[i] - tq[i-1] != 2) gap++;
    end
    chk("t1_data", bad, 0);
    chk("t1_spacing", gap, 0);
    tick(4);
    chk("t1_aux_done", bif.AUX, 1);
    chk("t1_fill_done", bif.fill_count, 0);

    // Idle flush
    q.delete();
    tq.delete();
    for (int i = 0; i < 10; i++) begin
      push(8'(8'h80 + i));
      p = cyc;
      tick(3);
    end
    chk("t2_no_early", q.size(), 0);
    wait_q(10, 150);
    chk("t2_count", q.size(), 10);
    chk("t2_latency", (tq[0] - p <= 102), 1);
    bad = 0;
    for (int i = 0; i < q.size(); i++)
      if (q[i] !== 8'(8'h80 + i)) bad++;
    chk("t2_data", bad, 0);
    tick(4);
    q.delete();
    tq.delete();
    for (int i = 0; i < 10; i++) begin
      push(8'(8'h90 + i));
      if (i < 9) tick(49);
    end
    chk("t2_no_flush_gaps", q.size(), 0);
    wait_q(10, 200);
    chk("t2b_count", q.size(), 10);
    tick(4);

    // Overflow with transmitter busy
    q.delete();
    tq.delete();
    bif.TX_flag_in = 1'b1;
    ov0 = ovf_cnt;
    bif.RX_flag_in = 1'b1;
    for (int k = 0; k < 515; k++) begin
      bif.data_in = 8'(k);
      tick(1);
    end
    bif.RX_flag_in = 1'b0;
    tick(2);
    chk("t3_fill", bif.fill_count, 512);
    chk("t3_ovf", ovf_cnt - ov0, 3);
`ifdef WIRELESS_TX_BUFFER_DROP_COUNTER_EN
    chk("t3_dropcnt", bif.drop_count, 3);
`endif
    chk("t3_blocked", q.size(), 0);
    chk("t3_aux", bif.AUX, 0);
    bif.TX_flag_in = 1'b0;
    wait_q(512, 1200);
    tick(4);
    chk("t3_count", q.size(), 512);
    bad = 0;
    for (int i = 0; i < q.size(); i++)
      if (q[i] !== 8'(i)) bad++;
    chk("t3_data", bad, 0);
    chk("t3_aux_done", bif.AUX, 1);

    // Push on pop cycle at full, then stall mid-burst
    q.delete();
    tq.delete();
    bif.TX_flag_in = 1'b1;
    bif.RX_flag_in = 1'b1;
    for (int k = 0; k < 512; k++) begin
      bif.data_in = 8'(k);
      tick(1);
    end
    bif.RX_flag_in = 1'b0;
    tick(1);
    chk("t5_full", bif.fill_count, 512);
    ov0 = ovf_cnt;
    bif.TX_flag_in = 1'b0;
    bif.RX_flag_in = 1'b1;
    bif.data_in = 8'hAB;
    tick(1);
    bif.RX_flag_in = 1'b0;
    chk("t5_fill_same", bif.fill_count, 512);
    tick(2);
    chk("t5_no_ovf", ovf_cnt - ov0, 0);

    wait_q(20, 100);
    bif.TX_flag_in = 1'b1;
    tick(2);
    n0 = q.size();
    tick(18);
    chk("t4_stalled", q.size(), n0);
    bif.TX_flag_in = 1'b0;
    e = cyc;
    n1 = q.size();
    wait_q(n1 + 1, 10);
    chk("t4_resume", tq[n1] - e, 1);
    wait_q(513, 1200);
    tick(4);
    chk("t45_count", q.size(), 513);
    bad = 0;
    for (int i = 0; i < 512 && i < q.size(); i++)
      if (q[i] !== 8'(i)) bad++;
    chk("t45_data", bad, 0);
    chk("t5_last", q[512], 8'hAB);

    // Reset mid-burst
    q.delete();
    tq.delete();
    bif.RX_flag_in = 1'b1;
    for (int k = 0; k < 100; k++) begin
      bif.data_in = 8'(k);
      tick(1);
    end
    bif.RX_flag_in = 1'b0;
    tick(20);
    chk("t6_busy", (q.size() != 0), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_txuse", bif.TX_use_out, 0);
    chk("t6_dout", bif.data_out, 0);
    chk("t6_aux", bif.AUX, 0);
    chk("t6_fill", bif.fill_count, 0);
    chk("t6_ovf", bif.overflow, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(1);
    chk("t6_aux_rel", bif.AUX, 1);
    chk("t6_fill_rel", bif.fill_count, 0);
    n0 = q.size();
    tick(50);
    chk("t6_silent", q.size(), n0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
